aes_prng_ctrl: RTL and testbench
================================

AES_PRNG_CTRL -- requirements
Module: aes_prng_ctrl

Interface
REQ-001 SHALL have parameter RESEED_PERIOD, default 1024: encryptions per seed; 0 = never force reseed.
REQ-002 SHALL have parameter SEED_W, default 80: PRNG seed width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port nrst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port seed_in, input, SEED_W, seed from the host.
REQ-006 SHALL have port seed_valid, input, 1, seed offer from the host.
REQ-007 SHALL have port seed_ready, output, 1, seed acceptance to the host.
REQ-008 SHALL have port host_valid, input, 1, encryption request from the host.
REQ-009 SHALL have port host_ready, output, 1, encryption acceptance to the host.
REQ-010 SHALL have port prng_seed, output, SEED_W, latched seed driven to the PRNG.
REQ-011 SHALL have port prng_start_reseed, output, 1, one-cycle reseed pulse.
REQ-012 SHALL have port prng_busy, input, 1, PRNG reseeding.
REQ-013 SHALL have ports prng_out_valid (input, 1) and prng_out_ready (output, 1), the PRNG randomness handshake.
REQ-014 SHALL have ports aes_valid_in (output, 1), aes_ready (input, 1) and aes_cipher_valid (input, 1), the masked-core start and done handshake.
REQ-015 SHALL have port need_seed, output, 1, high when no usable seed is loaded.
REQ-016 SHALL have port rnd_error, output, 1, sticky flag for a randomness underrun.

Function
REQ-017 SHALL implement states NOSEED, START, WAIT, READY, RUN.
REQ-018 NOSEED SHALL assert seed_ready; a seed_valid&seed_ready handshake latches seed_in into prng_seed and moves to START.
REQ-019 START SHALL assert prng_start_reseed for exactly one cycle, then move to WAIT.
REQ-020 WAIT SHALL ignore PRNG status on its first cycle, then move to READY when prng_busy=0 and prng_out_valid=1.
REQ-021 READY SHALL drive host_ready=aes_ready&prng_out_valid and aes_valid_in=host_valid&prng_out_valid, both combinational.
REQ-022 In READY, seed_ready SHALL be 1; seed_valid SHALL take priority over host_valid: host_ready=0 that cycle, seed latched, next state START.
REQ-023 A host_valid&host_ready handshake SHALL increment the encryption counter and move to RUN.
REQ-024 prng_out_ready SHALL be 1 on the acceptance cycle and every RUN cycle, and 0 otherwise.
REQ-025 If prng_out_valid=0 in any RUN cycle, rnd_error SHALL set and stay set until reset; the FSM continues.
REQ-026 RUN SHALL exit on aes_cipher_valid: to NOSEED with the counter cleared if RESEED_PERIOD≠0 and counter=RESEED_PERIOD, else to READY.
REQ-027 The counter SHALL be $clog2(RESEED_PERIOD+1) bits, never wrap, and be held at 0 when RESEED_PERIOD=0.
REQ-028 need_seed SHALL be 1 exactly in NOSEED.
REQ-029 seed_ready, host_ready and aes_valid_in SHALL be 0 in START, WAIT and RUN.

Reset
REQ-030 While nrst=0, the block SHALL hold state=NOSEED, counter=0, prng_seed=0 and rnd_error=0, and force every output to 0 except prng_seed (0) and need_seed (1).
REQ-031 Reset asserted mid-operation, including in RUN, SHALL abort the operation, and the first cycle after release SHALL be NOSEED with seed_ready=1.

Structure
REQ-032 Package aes_prng_ctrl_pkg SHALL hold the state enum and the SEED_W default constant.
REQ-033 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-034 Reset, then seed 80'h1234 -> prng_start_reseed pulses 1 cycle after handshake; READY reached once busy=0 and out_valid=1; need_seed 1->0.
REQ-035 RESEED_PERIOD=2, three host requests -> two encryptions complete, then NOSEED with need_seed=1, and the third request is held at host_ready=0.
REQ-036 Drop prng_out_valid for 1 cycle in RUN -> rnd_error=1 and stays 1 through later encryptions.
REQ-037 seed_valid and host_valid asserted together in READY -> seed accepted, aes_valid_in=0, state START.
REQ-038 nrst low for 1 cycle in RUN -> need_seed=1 and counter=0; a later aes_cipher_valid is ignored.
REQ-039 RESEED_PERIOD=0, 5000 encryptions -> never returns to NOSEED and counter stays 0.

Source files
------------

// File: rtl/aes_prng_ctrl_pkg.sv
// Shared types and constants for the AES/PRNG controller.
package aes_prng_ctrl_pkg;

  // Default seed width of the PRNG attached to the controller.
  localparam int unsigned SEED_W_DEFAULT = 80;

  // Controller states: no seed, reseed pulse, reseed in progress, idle, encrypting.
  typedef enum logic [2:0] {
    ST_NOSEED = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_READY  = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

endpackage

// File: rtl/aes_prng_ctrl.sv
// Sequences seeding of the PRNG and gates host encryption requests into the
// masked AES core, forcing a reseed after RESEED_PERIOD encryptions.
module aes_prng_ctrl
  import aes_prng_ctrl_pkg::*;
#(
  parameter int unsigned RESEED_PERIOD = 1024,
  parameter int unsigned SEED_W        = SEED_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [SEED_W-1:0] prng_seed,
  output logic              prng_start_reseed,
  input  logic              prng_busy,
  input  logic              prng_out_valid,
  output logic              prng_out_ready,
  output logic              aes_valid_in,
  input  logic              aes_ready,
  input  logic              aes_cipher_valid,
  output logic              need_seed,
  output logic              rnd_error
);

  // A period of 0 disables forced reseeding; keep a 1-bit counter tied at 0.
  localparam bit              PERIOD_EN = (RESEED_PERIOD != 0);
  localparam int unsigned     CNT_W     = PERIOD_EN ? $clog2(RESEED_PERIOD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESEED_PERIOD);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic              rnd_err_q, rnd_err_d;
  logic              wait_first_q, wait_first_d;

  logic seed_hs;
  logic host_hs;
  logic period_done;

  // A seed offer wins over a host request in READY, so the host handshake
  // also requires seed_valid to be low.
  assign seed_hs     = seed_valid & ((state_q == ST_NOSEED) | (state_q == ST_READY));
  assign host_hs     = (state_q == ST_READY) & ~seed_valid & host_valid
                     & aes_ready & prng_out_valid;
  assign period_done = PERIOD_EN & (cnt_q == CNT_MAX);

  // State register plus counter, seed latch and sticky error flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_NOSEED;
      cnt_q        <= '0;
      seed_q       <= '0;
      rnd_err_q    <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      // NOTE: every register in a clocked block uses <= so all of them see
      // the pre-edge values of each other, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seed_q       <= seed_d;
      rnd_err_q    <= rnd_err_d;
      wait_first_q <= wait_first_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: each variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    seed_d       = seed_q;
    wait_first_d = 1'b0;
    // An underrun anywhere in RUN is remembered until reset; the FSM carries on.
    rnd_err_d    = rnd_err_q | ((state_q == ST_RUN) & ~prng_out_valid);

    unique case (state_q)
      ST_NOSEED: begin
        if (seed_hs) begin
          seed_d  = seed_in;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d      = ST_WAIT;
        wait_first_d = 1'b1;
      end
      ST_WAIT: begin
        // PRNG status on the first WAIT cycle is stale (the reseed pulse has
        // not been seen yet), so it is ignored.
        if (!wait_first_q && !prng_busy && prng_out_valid) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (seed_hs) begin
          seed_d  = seed_in;
          state_d = ST_START;
        end else if (host_hs) begin
          state_d = ST_RUN;
          if (PERIOD_EN && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (aes_cipher_valid) begin
          if (period_done) begin
            state_d = ST_NOSEED;
            cnt_d   = '0;
          end else begin
            state_d = ST_READY;
          end
        end
      end
      default: state_d = ST_NOSEED;
    endcase
  end

  // Output decode; everything except need_seed is forced low while in reset.
  always_comb begin
    seed_ready        = 1'b0;
    host_ready        = 1'b0;
    aes_valid_in      = 1'b0;
    prng_start_reseed = 1'b0;
    prng_out_ready    = 1'b0;
    need_seed         = 1'b0;

    if (!nrst) begin
      need_seed = 1'b1;
    end else begin
      unique case (state_q)
        ST_NOSEED: begin
          seed_ready = 1'b1;
          need_seed  = 1'b1;
        end
        ST_START: prng_start_reseed = 1'b1;
        ST_WAIT:  ;
        ST_READY: begin
          seed_ready     = 1'b1;
          host_ready     = ~seed_valid & aes_ready & prng_out_valid;
          aes_valid_in   = ~seed_valid & host_valid & prng_out_valid;
          prng_out_ready = host_hs;
        end
        ST_RUN:   prng_out_ready = 1'b1;
        default:  ;
      endcase
    end
  end

  assign prng_seed = nrst ? seed_q : '0;
  assign rnd_error = nrst & rnd_err_q;

endmodule

// File: tb/tb_aes_prng_ctrl.sv
// Bench for aes_prng_ctrl: two instances (forced reseed every 2 encryptions,
// and never), emulated PRNG and AES core, transaction model and scoreboard.
module tb_aes_prng_ctrl;
  import aes_prng_ctrl_pkg::*;

  localparam int SW  = 80;
  localparam int P_A = 2;
  localparam int P_B = 0;

  typedef enum {EV_SEED, EV_ENC} ev_e;
  typedef struct {
    ev_e           kind;
    logic [SW-1:0] seed;
    bit            need_after;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  logic [SW-1:0] seed_in           [2];
  logic          seed_valid        [2];
  logic          seed_ready        [2];
  logic          host_valid        [2];
  logic          host_ready        [2];
  logic [SW-1:0] prng_seed         [2];
  logic          prng_start_reseed [2];
  logic          prng_busy         [2];
  logic          prng_out_valid    [2];
  logic          prng_out_ready    [2];
  logic          aes_valid_in      [2];
  logic          aes_ready         [2];
  logic          aes_cipher_valid  [2];
  logic          need_seed         [2];
  logic          rnd_error         [2];

  aes_prng_ctrl #(.RESEED_PERIOD(P_A), .SEED_W(SW)) dut_p2 (
    .clk(clk), .nrst(nrst),
    .seed_in(seed_in[0]), .seed_valid(seed_valid[0]), .seed_ready(seed_ready[0]),
    .host_valid(host_valid[0]), .host_ready(host_ready[0]),
    .prng_seed(prng_seed[0]), .prng_start_reseed(prng_start_reseed[0]),
    .prng_busy(prng_busy[0]), .prng_out_valid(prng_out_valid[0]),
    .prng_out_ready(prng_out_ready[0]),
    .aes_valid_in(aes_valid_in[0]), .aes_ready(aes_ready[0]),
    .aes_cipher_valid(aes_cipher_valid[0]),
    .need_seed(need_seed[0]), .rnd_error(rnd_error[0])
  );

  aes_prng_ctrl #(.RESEED_PERIOD(P_B), .SEED_W(SW)) dut_p0 (
    .clk(clk), .nrst(nrst),
    .seed_in(seed_in[1]), .seed_valid(seed_valid[1]), .seed_ready(seed_ready[1]),
    .host_valid(host_valid[1]), .host_ready(host_ready[1]),
    .prng_seed(prng_seed[1]), .prng_start_reseed(prng_start_reseed[1]),
    .prng_busy(prng_busy[1]), .prng_out_valid(prng_out_valid[1]),
    .prng_out_ready(prng_out_ready[1]),
    .aes_valid_in(aes_valid_in[1]), .aes_ready(aes_ready[1]),
    .aes_cipher_valid(aes_cipher_valid[1]),
    .need_seed(need_seed[1]), .rnd_error(rnd_error[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: encryptions since the last forced reseed and
  // whether a seed is currently required.
  int   enc_cnt  [2];
  bit   need_exp [2];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  // Emulator state.
  bit pr_arm  [2];
  int pr_cnt  [2];
  bit pr_drop [2];
  bit aes_go  [2];
  int aes_lat [2];

  // Monitor state.
  bit in_run     [2];
  bit prev_start [2];
  bit chk_need   [2];
  bit exp_need   [2];

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int period_of(input int d);
    return (d == 0) ? P_A : P_B;
  endfunction

  function automatic logic [SW-1:0] rand_seed();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[SW-1:0];
  endfunction

  function automatic void push_exp(input int d, input exp_t it);
    if (d == 0) exp_q0.push_back(it);
    else        exp_q1.push_back(it);
  endfunction

  function automatic bit pop_exp(input int d, output exp_t it);
    it.kind = EV_SEED; it.seed = '0; it.need_after = 1'b0;
    if (d == 0) begin
      if (exp_q0.size() == 0) return 1'b0;
      it = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) return 1'b0;
      it = exp_q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      enc_cnt[d]  = 0;
      need_exp[d] = 1'b1;
    end
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PRNG and AES core emulation: drive just after the rising edge, observe
  // on the falling edge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      pr_arm[d] = 0; pr_cnt[d] = 0; pr_drop[d] = 0; aes_go[d] = 0; aes_lat[d] = 0;
      prng_busy[d] = 1'b0; prng_out_valid[d] = 1'b1;
      aes_ready[d] = 1'b0; aes_cipher_valid[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        // One stale idle cycle after the reseed pulse, then busy for 1..4 cycles.
        if (pr_cnt[d] > 0) begin
          prng_busy[d] = 1'b1; prng_out_valid[d] = 1'b0; pr_cnt[d]--;
        end else if (pr_arm[d]) begin
          prng_busy[d] = 1'b0; prng_out_valid[d] = 1'b1; pr_arm[d] = 0;
          pr_cnt[d] = $urandom_range(1, 4);
        end else begin
          prng_busy[d] = 1'b0; prng_out_valid[d] = !pr_drop[d]; pr_drop[d] = 0;
        end
        aes_cipher_valid[d] = 1'b0;
        if (aes_go[d]) begin
          aes_go[d] = 0; aes_lat[d] = $urandom_range(2, 4); aes_ready[d] = 1'b0;
        end else if (aes_lat[d] > 0) begin
          aes_lat[d]--;
          if (aes_lat[d] == 0) aes_cipher_valid[d] = 1'b1;
          aes_ready[d] = 1'b0;
        end else begin
          aes_ready[d] = ($urandom_range(0, 3) != 0);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (nrst && prng_start_reseed[d]) pr_arm[d] = 1;
        if (nrst && aes_valid_in[d] && aes_ready[d]) aes_go[d] = 1;
      end
    end
  end

  // Scoreboard monitor: pops an expectation whenever the DUT starts a reseed
  // or accepts a host request, and tracks RUN for the randomness handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit   acc;
      bit   ok;
      exp_t it;
      if (!nrst) begin
        in_run[d] = 0; prev_start[d] = 0; chk_need[d] = 0;
      end else begin
        acc = host_valid[d] & host_ready[d];
        if (chk_need[d]) begin
          check($sformatf("need_seed_after_enc_%0d", d), need_seed[d], exp_need[d]);
          chk_need[d] = 0;
        end
        if (prev_start[d]) check($sformatf("reseed_pulse_width_%0d", d), prng_start_reseed[d], 0);
        if (prng_start_reseed[d] && !prev_start[d]) begin
          ok = pop_exp(d, it);
          check($sformatf("reseed_expected_%0d", d), ok, 1);
          if (ok) begin
            check($sformatf("reseed_kind_%0d", d), it.kind == EV_SEED, 1);
            check($sformatf("prng_seed_%0d", d), prng_seed[d], it.seed);
          end
        end
        prev_start[d] = prng_start_reseed[d];
        if (acc) begin
          ok = pop_exp(d, it);
          check($sformatf("accept_expected_%0d", d), ok, 1);
          if (ok) check($sformatf("accept_kind_%0d", d), it.kind == EV_ENC, 1);
          check($sformatf("aes_valid_in_on_accept_%0d", d), aes_valid_in[d], 1);
          exp_need[d] = it.need_after;
        end
        check($sformatf("prng_out_ready_%0d", d), prng_out_ready[d], acc | in_run[d]);
        if (in_run[d] && aes_cipher_valid[d]) begin
          in_run[d] = 0; chk_need[d] = 1;
        end
        if (acc) in_run[d] = 1;
      end
    end
  end

  // Wait for READY (seed_ready high while need_seed low).
  task automatic wait_ready(input int d);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (seed_ready[d] && !need_seed[d]) got = 1;
      tick();
    end
    check($sformatf("reach_ready_%0d", d), got, 1);
  endtask

  task automatic do_seed(input int d, input logic [SW-1:0] s);
    exp_t it;
    bit   got = 0;
    it.kind = EV_SEED; it.seed = s; it.need_after = 1'b0;
    push_exp(d, it);
    seed_in[d] = s; seed_valid[d] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (seed_ready[d]) got = 1;
      tick();
    end
    check($sformatf("seed_handshake_%0d", d), got, 1);
    seed_valid[d] = 1'b0;
    need_exp[d] = 1'b0;
    wait_ready(d);
  endtask

  // One host request; drop injects a randomness gap in the first RUN cycle,
  // rst_mid pulses reset in the first RUN cycle.
  task automatic do_enc(input int d, input bit drop, input bit rst_mid);
    exp_t it;
    bit   got = 0;
    bit   need_after;
    if (need_exp[d]) begin
      host_valid[d] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check($sformatf("blocked_host_ready_%0d", d), host_ready[d], 0);
        check($sformatf("blocked_aes_valid_%0d", d), aes_valid_in[d], 0);
        tick();
      end
      host_valid[d] = 1'b0;
      return;
    end
    need_after = (period_of(d) != 0) && (enc_cnt[d] + 1 == period_of(d));
    enc_cnt[d] = need_after ? 0 : enc_cnt[d] + 1;
    it.kind = EV_ENC; it.seed = '0; it.need_after = need_after;
    push_exp(d, it);
    host_valid[d] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (host_ready[d]) begin
        got = 1;
        if (drop) pr_drop[d] = 1;
      end
      tick();
    end
    check($sformatf("host_handshake_%0d", d), got, 1);
    host_valid[d] = 1'b0;
    if (rst_mid) begin
      nrst = 1'b0;
      @(negedge clk);
      check("rst_run_need_seed", need_seed[d], 1);
      check("rst_run_seed_ready", seed_ready[d], 0);
      check("rst_run_out_ready", prng_out_ready[d], 0);
      check("rst_run_prng_seed", prng_seed[d], 0);
      check("rst_run_host_ready", host_ready[d], 0);
      check("rst_run_aes_valid", aes_valid_in[d], 0);
      tick();
      nrst = 1'b1;
      model_reset();
      @(negedge clk);
      check("rst_release_need_seed", need_seed[d], 1);
      check("rst_release_seed_ready", seed_ready[d], 1);
      tick();
      repeat (8) tick();
      @(negedge clk);
      check("late_cipher_ignored", need_seed[d], 1);
      tick();
      return;
    end
    if (need_after) need_exp[d] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (seed_ready[d]) got = 1;
      tick();
    end
    check($sformatf("enc_done_%0d", d), got, 1);
  endtask

  initial begin
    exp_t it;
    for (int d = 0; d < 2; d++) begin
      seed_in[d] = '0; seed_valid[d] = 1'b0; host_valid[d] = 1'b0;
    end
    model_reset();

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_need_seed_%0d", d), need_seed[d], 1);
      check($sformatf("reset_seed_ready_%0d", d), seed_ready[d], 0);
      check($sformatf("reset_prng_seed_%0d", d), prng_seed[d], 0);
      check($sformatf("reset_rnd_error_%0d", d), rnd_error[d], 0);
      check($sformatf("reset_start_%0d", d), prng_start_reseed[d], 0);
    end
    tick();
    nrst = 1'b1;
    @(negedge clk);
    check("post_reset_seed_ready", seed_ready[0], 1);
    check("post_reset_need_seed", need_seed[0], 1);
    tick();

    // Seed 80'h1234: pulse after handshake, WAIT ignores stale status, then READY.
    it.kind = EV_SEED; it.seed = 80'h1234; it.need_after = 1'b0;
    push_exp(0, it);
    seed_in[0] = 80'h1234; seed_valid[0] = 1'b1;
    @(negedge clk);
    check("seed_ready_noseed", seed_ready[0], 1);
    tick();
    seed_valid[0] = 1'b0;
    need_exp[0] = 1'b0;
    @(negedge clk);
    check("start_pulse", prng_start_reseed[0], 1);
    check("need_seed_cleared", need_seed[0], 0);
    tick();
    @(negedge clk);
    check("wait_first_seed_ready", seed_ready[0], 0);
    tick();
    @(negedge clk);
    check("wait_second_seed_ready", seed_ready[0], 0);
    tick();
    wait_ready(0);
    check("rnd_error_clean", rnd_error[0], 0);

    // Period 2: two encryptions, then the third request is held off.
    do_enc(0, 0, 0);
    do_enc(0, 0, 0);
    do_enc(0, 0, 0);
    @(negedge clk);
    check("period_need_seed", need_seed[0], 1);
    tick();

    // Randomness underrun in RUN is sticky across later encryptions and reseeds.
    do_seed(0, rand_seed());
    do_enc(0, 1, 0);
    @(negedge clk);
    check("rnd_error_set", rnd_error[0], 1);
    tick();
    do_enc(0, 0, 0);
    do_seed(0, rand_seed());
    do_enc(0, 0, 0);
    @(negedge clk);
    check("rnd_error_sticky", rnd_error[0], 1);
    tick();

    // Seed and host request together in READY: the seed wins.
    it.kind = EV_SEED; it.seed = rand_seed(); it.need_after = 1'b0;
    push_exp(0, it);
    seed_in[0] = it.seed; seed_valid[0] = 1'b1; host_valid[0] = 1'b1;
    @(negedge clk);
    check("prio_aes_valid_in", aes_valid_in[0], 0);
    check("prio_host_ready", host_ready[0], 0);
    check("prio_seed_ready", seed_ready[0], 1);
    tick();
    seed_valid[0] = 1'b0; host_valid[0] = 1'b0;
    @(negedge clk);
    check("prio_start", prng_start_reseed[0], 1);
    tick();
    wait_ready(0);

    // Reset pulse in RUN, then the counter must restart from zero.
    do_enc(0, 0, 1);
    @(negedge clk);
    check("rnd_error_cleared_by_reset", rnd_error[0], 0);
    tick();
    do_seed(0, rand_seed());
    do_enc(0, 0, 0);
    do_enc(0, 0, 0);

    // Randomized mix of reseeds, requests and idle gaps.
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2 || (need_exp[0] && r < 6)) do_seed(0, rand_seed());
      else do_enc(0, 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // No forced reseed: 5000 encryptions never return to NOSEED.
    do_seed(1, rand_seed());
    for (int i = 0; i < 5000; i++) begin
      if (i % 1000 == 500) do_seed(1, rand_seed());
      do_enc(1, 0, 0);
    end
    @(negedge clk);
    check("p0_need_seed", need_seed[1], 0);
    check("p0_counter", dut_p0.cnt_q, 0);
    tick();

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
